// File: rtl/bcd_subtractor_seq_if.sv
// Start/done handshake bundle for the sequential BCD subtractor.
interface bcd_subtractor_seq_if #(
  parameter int DIGITS = 4
) ();
  logic                  start;
  logic [4*DIGITS-1:0]   a;
  logic [4*DIGITS-1:0]   b;
  logic                  bin;
  logic                  busy;
  logic                  done;
  logic [4*DIGITS-1:0]   diff;
  logic                  bout;
  logic                  err;

  modport master (
    output start, a, b, bin,
    input  busy, done, diff, bout, err
  );

  modport slave (
    input  start, a, b, bin,
    output busy, done, diff, bout, err
  );
endinterface

// File: rtl/bcd_subtractor_seq.sv
// Digit-serial packed-BCD subtractor: diff = a - b - bin, LSD first, one digit per clock.
// Optional operand digit checking is enabled by defining BCD_SUB_CHECK_EN.
module bcd_subtractor_seq #(
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  bcd_subtractor_seq_if.slave   bus
);
  localparam int W    = 4 * DIGITS;
  localparam int KW   = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [KW-1:0] LAST_K = KW'(DIGITS - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

  state_t        state_q, state_d;
  logic [KW-1:0] k_q, k_d;
  logic [W-1:0]  a_q, a_d;
  logic [W-1:0]  b_q, b_d;
  logic [W-1:0]  acc_q, acc_d;
  logic          borrow_q, borrow_d;
  logic [W-1:0]  diff_q, diff_d;
  logic          bout_q, bout_d;
  logic          err_q, err_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;

  logic [3:0]    a_dig_s, b_dig_s, digit_s;
  logic [4:0]    t_s;
  logic [W-1:0]  acc_nx_s;

`ifdef BCD_SUB_CHECK_EN
  logic          inval_q, inval_d;
  logic          bad_dig_s;
`endif

  // One digit of subtraction on the low nibbles of the shifting operand registers.
  always_comb begin
    a_dig_s  = a_q[3:0];
    b_dig_s  = b_q[3:0];
    t_s      = {1'b0, a_dig_s} - {1'b0, b_dig_s} - {4'b0000, borrow_q};
    if (t_s[4]) begin
      digit_s = t_s[3:0] + 4'd10;
    end else begin
      digit_s = t_s[3:0];
    end
    // Results enter at the top so digit 0 lands at bits [3:0] after DIGITS shifts.
    acc_nx_s = (acc_q >> 4) | (W'(digit_s) << (W - 4));
`ifdef BCD_SUB_CHECK_EN
    bad_dig_s = (a_dig_s > 4'd9) || (b_dig_s > 4'd9);
`endif
  end

  // Next-state and next-output computation.
  always_comb begin
    state_d  = state_q;
    k_d      = k_q;
    a_d      = a_q;
    b_d      = b_q;
    acc_d    = acc_q;
    borrow_d = borrow_q;
    diff_d   = diff_q;
    bout_d   = bout_q;
    err_d    = err_q;
    busy_d   = 1'b0;
    done_d   = 1'b0;
`ifdef BCD_SUB_CHECK_EN
    inval_d  = inval_q;
`endif
    case (state_q)
      IDLE, DONE: begin
        if (bus.start) begin
          state_d  = RUN;
          busy_d   = 1'b1;
          a_d      = bus.a;
          b_d      = bus.b;
          borrow_d = bus.bin;
          k_d      = '0;
          acc_d    = '0;
`ifdef BCD_SUB_CHECK_EN
          inval_d  = 1'b0;
`endif
        end else begin
          state_d  = IDLE;
        end
      end
      RUN: begin
        a_d      = a_q >> 4;
        b_d      = b_q >> 4;
        acc_d    = acc_nx_s;
        borrow_d = t_s[4];
        k_d      = k_q + KW'(1);
`ifdef BCD_SUB_CHECK_EN
        inval_d  = inval_q | bad_dig_s;
`endif
        if (k_q == LAST_K) begin
          state_d = DONE;
          done_d  = 1'b1;
          busy_d  = 1'b0;
`ifdef BCD_SUB_CHECK_EN
          if (inval_q || bad_dig_s) begin
            err_d  = 1'b1;
            diff_d = '0;
            bout_d = 1'b0;
          end else begin
            err_d  = 1'b0;
            diff_d = acc_nx_s;
            bout_d = t_s[4];
          end
`else
          err_d  = 1'b0;
          diff_d = acc_nx_s;
          bout_d = t_s[4];
`endif
        end else begin
          busy_d = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers; reset aborts any operation in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      k_q      <= '0;
      a_q      <= '0;
      b_q      <= '0;
      acc_q    <= '0;
      borrow_q <= 1'b0;
      diff_q   <= '0;
      bout_q   <= 1'b0;
      err_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
`ifdef BCD_SUB_CHECK_EN
      inval_q  <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      k_q      <= k_d;
      a_q      <= a_d;
      b_q      <= b_d;
      acc_q    <= acc_d;
      borrow_q <= borrow_d;
      diff_q   <= diff_d;
      bout_q   <= bout_d;
      err_q    <= err_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
`ifdef BCD_SUB_CHECK_EN
      inval_q  <= inval_d;
`endif
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.diff = diff_q;
  assign bus.bout = bout_q;
  assign bus.err  = err_q;
endmodule

// File: tb/tb_bcd_subtractor_seq.sv
// Scoreboard bench for bcd_subtractor_seq: a 4-digit and a 1-digit instance.
module tb_bcd_subtractor_seq;
  typedef struct packed {
    logic [15:0] diff;
    logic        bout;
    logic        err;
  } exp4_t;

  typedef struct packed {
    logic [3:0] diff;
    logic       bout;
    logic       err;
  } exp1_t;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  exp4_t exp4_q[$];
  exp1_t exp1_q[$];

  bcd_subtractor_seq_if #(.DIGITS(4)) if4 ();
  bcd_subtractor_seq_if #(.DIGITS(1)) if1 ();

  bcd_subtractor_seq #(.DIGITS(4)) dut4 (.clk(clk), .rst(rst), .bus(if4));
  bcd_subtractor_seq #(.DIGITS(1)) dut1 (.clk(clk), .rst(rst), .bus(if1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Monitor for the 4-digit instance.
  always @(negedge clk) begin
    if (!rst && if4.done) begin
      if (exp4_q.size() == 0) begin
        chk("done4_unexpected", 32'd1, 32'd0);
      end else begin
        exp4_t e;
        e = exp4_q.pop_front();
        chk("diff4", {16'd0, if4.diff}, {16'd0, e.diff});
        chk("bout4", {31'd0, if4.bout}, {31'd0, e.bout});
        chk("err4",  {31'd0, if4.err},  {31'd0, e.err});
      end
    end
  end

  // Monitor for the 1-digit instance.
  always @(negedge clk) begin
    if (!rst && if1.done) begin
      if (exp1_q.size() == 0) begin
        chk("done1_unexpected", 32'd1, 32'd0);
      end else begin
        exp1_t e;
        e = exp1_q.pop_front();
        chk("diff1", {28'd0, if1.diff}, {28'd0, e.diff});
        chk("bout1", {31'd0, if1.bout}, {31'd0, e.bout});
        chk("err1",  {31'd0, if1.err},  {31'd0, e.err});
      end
    end
  end

  task automatic do_op4(input logic [15:0] av, input logic [15:0] bv, input logic bi,
                        input logic [15:0] ed, input logic eb, input logic ee);
    int lat;
    int busy_cnt;
    exp4_q.push_back('{diff: ed, bout: eb, err: ee});
    if4.a     = av;
    if4.b     = bv;
    if4.bin   = bi;
    if4.start = 1'b1;
    @(posedge clk);
    #1;
    if4.start = 1'b0;
    lat = 0;
    busy_cnt = 0;
    while (!if4.done && lat < 20) begin
      if (if4.busy) busy_cnt++;
      @(posedge clk);
      #1;
      lat++;
    end
    chk("latency4", lat, 32'd4);
    chk("busy_cycles4", busy_cnt, 32'd4);
    chk("busy_at_done4", {31'd0, if4.busy}, 32'd0);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    if4.start = 1'b0; if4.a = '0; if4.b = '0; if4.bin = 1'b0;
    if1.start = 1'b0; if1.a = '0; if1.b = '0; if1.bin = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_busy", {31'd0, if4.busy}, 32'd0);
    chk("rst_done", {31'd0, if4.done}, 32'd0);
    chk("rst_diff", {16'd0, if4.diff}, 32'd0);
    chk("rst_bout", {31'd0, if4.bout}, 32'd0);
    chk("rst_err",  {31'd0, if4.err},  32'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    do_op4(16'h0042, 16'h0017, 1'b0, 16'h0025, 1'b0, 1'b0);
    do_op4(16'h0000, 16'h0001, 1'b0, 16'h9999, 1'b1, 1'b0);
    do_op4(16'h5000, 16'h4999, 1'b1, 16'h0000, 1'b0, 1'b0);
    do_op4(16'h1000, 16'h0001, 1'b0, 16'h0999, 1'b0, 1'b0);
    do_op4(16'h9999, 16'h9999, 1'b1, 16'h9999, 1'b1, 1'b0);

    // Start held high: operands change during RUN and must not disturb the first result.
    begin
      int lat;
      exp4_q.push_back('{diff: 16'h1000, bout: 1'b0, err: 1'b0});
      exp4_q.push_back('{diff: 16'h9900, bout: 1'b1, err: 1'b0});
      if4.a = 16'h1234; if4.b = 16'h0234; if4.bin = 1'b0;
      if4.start = 1'b1;
      @(posedge clk);
      #1;
      if4.a = 16'h0100; if4.b = 16'h0200;
      lat = 0;
      while (!if4.done && lat < 20) begin
        @(posedge clk);
        #1;
        lat++;
      end
      chk("held_first_latency", lat, 32'd4);
      lat = 0;
      @(posedge clk);
      #1;
      lat++;
      while (!if4.done && lat < 20) begin
        @(posedge clk);
        #1;
        lat++;
      end
      chk("done_spacing", lat, 32'd5);
      if4.start = 1'b0;
      @(posedge clk);
      #1;
      chk("idle_after_held", {30'd0, if4.busy, if4.done}, 32'd0);
    end

    // Reset mid-operation: outputs clear at once and no done follows.
    if4.a = 16'h0042; if4.b = 16'h0017; if4.bin = 1'b0;
    if4.start = 1'b1;
    @(posedge clk);
    #1;
    if4.start = 1'b0;
    @(posedge clk);
    #1;
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk("abort_busy", {31'd0, if4.busy}, 32'd0);
    chk("abort_done", {31'd0, if4.done}, 32'd0);
    chk("abort_diff", {16'd0, if4.diff}, 32'd0);
    chk("abort_bout", {31'd0, if4.bout}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("abort_no_done", {30'd0, if4.busy, if4.done}, 32'd0);
    do_op4(16'h0042, 16'h0017, 1'b0, 16'h0025, 1'b0, 1'b0);

`ifdef BCD_SUB_CHECK_EN
    do_op4(16'h00A3, 16'h0001, 1'b0, 16'h0000, 1'b0, 1'b1);
    do_op4(16'h0300, 16'h0001, 1'b0, 16'h0299, 1'b0, 1'b0);
`endif

    // Exhaustive single-digit sweep against (a - b - bin) mod 10.
    for (int av = 0; av < 10; av++) begin
      for (int bv = 0; bv < 10; bv++) begin
        for (int bi = 0; bi < 2; bi++) begin
          int r;
          int lat;
          r = av - bv - bi;
          exp1_q.push_back('{diff: 4'((r + 20) % 10), bout: (r < 0), err: 1'b0});
          if1.a = 4'(av); if1.b = 4'(bv); if1.bin = bi[0];
          if1.start = 1'b1;
          @(posedge clk);
          #1;
          if1.start = 1'b0;
          lat = 0;
          while (!if1.done && lat < 10) begin
            @(posedge clk);
            #1;
            lat++;
          end
          chk("latency1", lat, 32'd1);
        end
      end
    end

    repeat (3) @(posedge clk);
    #1;
    chk("queue4_drained", exp4_q.size(), 32'd0);
    chk("queue1_drained", exp1_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
